// File: rtl/pong_tone_gen_if.sv
// Avalon-MM slave bus bundle for pong_tone_gen.
// Handshake: a write or read is accepted in every cycle its strobe is high (no waitrequest);
// avs_readdata is valid in the cycle after avs_read and holds until the next read.
interface pong_tone_gen_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/pong_tone_gen.sv
// DDS tone generator for game beeps: phase accumulator into a 64-entry sine LUT, one sample per tick.
// Optional square wave via CTRL[3] WAVE when TONE_GEN_SQUARE_EN is defined.
module pong_tone_gen #(
    parameter int ACC_W      = 24,
    parameter int SAMPLE_DIV = 1042,
    parameter int DUR_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    pong_tone_gen_if.slave    avs,
    output logic [6:0]        sample_out,
    output logic              sample_valid,
    output logic [1:0]        dbg_state
);
    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        CONT  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              tick_d;
    logic              active_d;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  phase_inc;
    logic [DUR_W-1:0]  duration;
    logic [DUR_W-1:0]  remaining;
    logic              cont_bit;
    logic              ctrl_wr;
    logic              cont_next;
    logic              start_req;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

`ifdef TONE_GEN_SQUARE_EN
    logic wave_bit;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wave_bit <= 1'b0;
        end else if (ctrl_wr) begin
            wave_bit <= avs.avs_writedata[3];
        end
    end
`else
    logic wave_bit;
    assign wave_bit = 1'b0;
`endif

    function automatic logic [6:0] sine_lut(input logic [5:0] idx);
        sine_lut = 7'd64;
        case (idx)
            6'd0:  sine_lut = 7'd64;  6'd1:  sine_lut = 7'd70;  6'd2:  sine_lut = 7'd76;  6'd3:  sine_lut = 7'd82;
            6'd4:  sine_lut = 7'd88;  6'd5:  sine_lut = 7'd93;  6'd6:  sine_lut = 7'd99;  6'd7:  sine_lut = 7'd104;
            6'd8:  sine_lut = 7'd108; 6'd9:  sine_lut = 7'd113; 6'd10: sine_lut = 7'd116; 6'd11: sine_lut = 7'd120;
            6'd12: sine_lut = 7'd122; 6'd13: sine_lut = 7'd124; 6'd14: sine_lut = 7'd126; 6'd15: sine_lut = 7'd127;
            6'd16: sine_lut = 7'd127; 6'd17: sine_lut = 7'd127; 6'd18: sine_lut = 7'd126; 6'd19: sine_lut = 7'd124;
            6'd20: sine_lut = 7'd122; 6'd21: sine_lut = 7'd120; 6'd22: sine_lut = 7'd116; 6'd23: sine_lut = 7'd113;
            6'd24: sine_lut = 7'd108; 6'd25: sine_lut = 7'd104; 6'd26: sine_lut = 7'd99;  6'd27: sine_lut = 7'd93;
            6'd28: sine_lut = 7'd88;  6'd29: sine_lut = 7'd82;  6'd30: sine_lut = 7'd76;  6'd31: sine_lut = 7'd70;
            6'd32: sine_lut = 7'd64;  6'd33: sine_lut = 7'd57;  6'd34: sine_lut = 7'd51;  6'd35: sine_lut = 7'd45;
            6'd36: sine_lut = 7'd39;  6'd37: sine_lut = 7'd34;  6'd38: sine_lut = 7'd28;  6'd39: sine_lut = 7'd23;
            6'd40: sine_lut = 7'd19;  6'd41: sine_lut = 7'd14;  6'd42: sine_lut = 7'd11;  6'd43: sine_lut = 7'd7;
            6'd44: sine_lut = 7'd5;   6'd45: sine_lut = 7'd3;   6'd46: sine_lut = 7'd1;   6'd47: sine_lut = 7'd0;
            6'd48: sine_lut = 7'd0;   6'd49: sine_lut = 7'd0;   6'd50: sine_lut = 7'd1;   6'd51: sine_lut = 7'd3;
            6'd52: sine_lut = 7'd5;   6'd53: sine_lut = 7'd7;   6'd54: sine_lut = 7'd11;  6'd55: sine_lut = 7'd14;
            6'd56: sine_lut = 7'd19;  6'd57: sine_lut = 7'd23;  6'd58: sine_lut = 7'd28;  6'd59: sine_lut = 7'd34;
            6'd60: sine_lut = 7'd39;  6'd61: sine_lut = 7'd45;  6'd62: sine_lut = 7'd51;  6'd63: sine_lut = 7'd57;
            default: sine_lut = 7'd64;
        endcase
    endfunction

    assign tick         = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign ctrl_wr      = avs.avs_write && (avs.avs_address == 2'd0);
    // CONT is decided from the value being written this cycle so it beats a START in the same write.
    assign cont_next    = ctrl_wr ? avs.avs_writedata[0] : cont_bit;
    assign start_req    = ctrl_wr && avs.avs_writedata[1] && (duration != '0);
    assign dbg_state    = state;
    assign unused_wdata = ^avs.avs_writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cont_bit  <= 1'b0;
            phase_inc <= '0;
            duration  <= '0;
        end else if (avs.avs_write) begin
            case (avs.avs_address)
                2'd0:    cont_bit  <= avs.avs_writedata[0];
                2'd1:    phase_inc <= avs.avs_writedata[ACC_W-1:0];
                2'd2:    duration  <= avs.avs_writedata[DUR_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            tick_d    <= 1'b0;
            active_d  <= 1'b0;
        end else begin
            tick_d   <= tick;
            active_d <= tick && (state != IDLE);
            if (tick && (state != IDLE)) begin
                acc <= acc + phase_inc;
            end
            case (state)
                IDLE: begin
                    if (cont_next) begin
                        state <= CONT;
                    end else if (start_req) begin
                        state     <= BURST;
                        remaining <= duration;
                        acc       <= '0;
                    end
                end
                BURST: begin
                    if (cont_next) begin
                        state <= CONT;
                    end else if (start_req) begin
                        remaining <= duration;
                    end else if (tick) begin
                        remaining <= remaining - DUR_W'(1);
                        if (remaining == DUR_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                CONT: begin
                    if (!cont_next) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The sample lands one clock after the tick, from the accumulator value that tick produced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_out   <= 7'd64;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= tick_d;
            if (tick_d) begin
                if (!active_d) begin
                    sample_out <= 7'd64;
                end else if (wave_bit) begin
                    sample_out <= acc[ACC_W-1] ? 7'd0 : 7'd127;
                end else begin
                    sample_out <= sine_lut(acc[ACC_W-1 -: 6]);
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            2'd0: begin
                rd_mux[0] = cont_bit;
                rd_mux[2] = (state != IDLE);
                rd_mux[3] = wave_bit;
            end
            2'd1:    rd_mux[ACC_W-1:0] = phase_inc;
            2'd2:    rd_mux[DUR_W-1:0] = duration;
            2'd3:    rd_mux[6:0]       = sample_out;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.avs_readdata <= '0;
        end else if (avs.avs_read) begin
            avs.avs_readdata <= rd_mux;
        end
    end
endmodule
